game_flow_ctrl: RTL and testbench

//  Parametrised game-flow FSM for the frog game. Arbitrates per-pixel draw requests into a mux select.

---
 rtl/game_pkg.sv | 39 +++
 rtl/game_flow_ctrl_buzz_timer.sv | 31 +++
 rtl/game_flow_ctrl.sv | 179 +++++++++++++++++
 tb/tb_game_flow_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared types and helpers for the frog game flow controller: FSM states,
// draw-layer select codes and the log enable mask rule.
package game_pkg;

    typedef enum logic [2:0] {
        ST_PLAY = 3'd0,
        ST_HIT  = 3'd1,
        ST_GOAL = 3'd2,
        ST_BUZ  = 3'd3,
        ST_OVER = 3'd4
    } game_state_t;

    function automatic logic [7:0] haz_code(input int idx);
        return 8'(idx + 1);
    endfunction

    function automatic logic [7:0] gate_code(input int num_haz, input int idx);
        return 8'(num_haz + 1 + idx);
    endfunction

    function automatic logic [7:0] frog_code(input int num_haz, input int num_gate);
        return 8'(num_haz + num_gate + 1);
    endfunction

    function automatic logic [7:0] bank_code(input int num_haz, input int num_gate);
        return 8'(num_haz + num_gate + 2);
    endfunction

    // One bit of the enabled-log mask: the low min(log_num, base+(level-1)*step) bits are set.
    function automatic logic log_mask(input int level, input int bit_idx, input int log_num,
                                      input int base, input int step);
        int raw_cnt;
        int cnt;
        raw_cnt = base + (level - 1) * step;
        cnt     = (raw_cnt > log_num) ? log_num : raw_cnt;
        return (bit_idx < cnt) ? 1'b1 : 1'b0;
    endfunction

endpackage

// File: rtl/game_flow_ctrl_buzz_timer.sv
// Down-counter for the sound burst: load sets the full length, done flags the
// last cycle of the burst.
module buzz_timer #(
    parameter int CYCLES = 50000000
) (
    input  logic clk,
    input  logic resetN,
    input  logic load,
    output logic done
);

    localparam int CNT_W = $clog2(CYCLES + 1);

    logic [CNT_W-1:0] cnt_r;

    // Burst counter: reload on request, otherwise count down to zero and rest there.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (load) begin
            cnt_r <= CNT_W'(CYCLES);
        end else if (cnt_r != {CNT_W{1'b0}}) begin
            cnt_r <= cnt_r - CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign done = (cnt_r == CNT_W'(1));

endmodule

// File: rtl/game_flow_ctrl.sv
// Frog game flow controller: per-pixel draw arbitration, win/lose detection,
// level/lives bookkeeping, log enable mask and win/lose sound burst timing.
module game_flow_ctrl
    import game_pkg::*;
#(
    parameter int NUM_HAZ    = 3,
    parameter int NUM_GATE   = 2,
    parameter int LOG_NUM    = 15,
    parameter int LOGS_BASE  = 1,
    parameter int LOGS_STEP  = 5,
    parameter int MAX_LEVEL  = 4,
    parameter int LIVES      = 3,
    parameter int BUZ_CYCLES = 50000000,
    parameter int FREQ_W     = 10,
    parameter int WIN_FREQ   = 500,
    parameter int LOSE_FREQ  = 950,
    localparam int GID_W     = (NUM_GATE > 1) ? $clog2(NUM_GATE) : 1,
    localparam int LVL_W     = $clog2(MAX_LEVEL + 1),
    localparam int LIV_W     = $clog2(LIVES + 1)
) (
    input  logic                clk,
    input  logic                resetN,
    input  logic [NUM_HAZ-1:0]  hazard_draw_req,
    input  logic [NUM_GATE-1:0] gate_draw_req,
    input  logic                frog_draw_req,
    input  logic                endbank_draw_req,
    input  logic                restart,
    output logic [7:0]          select_mux,
    output logic                take_gate,
    output logic [GID_W-1:0]    gate_id,
    output logic                win,
    output logic                lose,
    output logic                enable_sound,
    output logic [FREQ_W-1:0]   sound_freq_out,
    output logic [LOG_NUM-1:0]  log_enable_out,
    output logic [LVL_W-1:0]    level_out,
    output logic [LIV_W-1:0]    lives_out,
    output logic                game_over
);

    localparam logic [LVL_W-1:0] LVL_MIN  = LVL_W'(1);
    localparam logic [LVL_W-1:0] LVL_TOP  = LVL_W'(MAX_LEVEL);
    localparam logic [LIV_W-1:0] LIV_FULL = LIV_W'(LIVES);
    localparam logic [LIV_W-1:0] LIV_NONE = LIV_W'(0);

    game_state_t         state_r;
    logic [LVL_W-1:0]    level_r;
    logic [LIV_W-1:0]    lives_r;
    logic [FREQ_W-1:0]   freq_r;
    logic                win_r;
    logic                lose_r;
    logic                sound_r;
    logic                over_r;
    logic                load_s;
    logic                done_s;
    logic [7:0]          sel_s;
    logic [GID_W-1:0]    gid_s;
    logic                gate_top_s;
    logic [LOG_NUM-1:0]  log_en_s;

    assign load_s = (state_r == ST_HIT) || (state_r == ST_GOAL);

    buzz_timer #(
        .CYCLES (BUZ_CYCLES)
    ) u_buzz_timer (
        .clk    (clk),
        .resetN (resetN),
        .load   (load_s),
        .done   (done_s)
    );

    // Priority encoder: apply layers lowest priority first so higher layers overwrite.
    always_comb begin
        sel_s = endbank_draw_req ? bank_code(NUM_HAZ, NUM_GATE) : 8'd0;
        sel_s = frog_draw_req ? frog_code(NUM_HAZ, NUM_GATE) : sel_s;
        gid_s = {GID_W{1'b0}};
        for (int g = NUM_GATE - 1; g >= 0; g--) begin
            sel_s = gate_draw_req[g] ? gate_code(NUM_HAZ, g) : sel_s;
            gid_s = gate_draw_req[g] ? GID_W'(g) : gid_s;
        end
        for (int i = NUM_HAZ - 1; i >= 0; i--) begin
            sel_s = hazard_draw_req[i] ? haz_code(i) : sel_s;
        end
        gate_top_s = (|gate_draw_req) && !(|hazard_draw_req);
    end

    // Enabled-log mask derived from the current level.
    always_comb begin
        log_en_s = {LOG_NUM{1'b0}};
        for (int b = 0; b < LOG_NUM; b++) begin
            log_en_s[b] = log_mask(int'(level_r), b, LOG_NUM, LOGS_BASE, LOGS_STEP);
        end
    end

    // Game flow FSM with registered event, sound and game-over outputs.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            state_r <= ST_PLAY;
            level_r <= LVL_MIN;
            lives_r <= LIV_FULL;
            freq_r  <= {FREQ_W{1'b0}};
            win_r   <= 1'b0;
            lose_r  <= 1'b0;
            sound_r <= 1'b0;
            over_r  <= 1'b0;
        end else begin
            win_r  <= 1'b0;
            lose_r <= 1'b0;
            case (state_r)
                ST_PLAY: begin
                    // A hazard coincidence wins over an end-bank coincidence on the same pixel.
                    if (frog_draw_req && (|hazard_draw_req)) begin
                        state_r <= ST_HIT;
                        lose_r  <= 1'b1;
                    end else if (frog_draw_req && endbank_draw_req) begin
                        state_r <= ST_GOAL;
                        win_r   <= 1'b1;
                    end else begin
                        state_r <= ST_PLAY;
                    end
                end
                ST_HIT: begin
                    freq_r  <= FREQ_W'(LOSE_FREQ);
                    lives_r <= (lives_r != LIV_NONE) ? lives_r - LIV_W'(1) : LIV_NONE;
                    level_r <= (level_r > LVL_MIN) ? level_r - LVL_W'(1) : LVL_MIN;
                    sound_r <= 1'b1;
                    state_r <= ST_BUZ;
                end
                ST_GOAL: begin
                    freq_r  <= FREQ_W'(WIN_FREQ);
                    level_r <= (level_r < LVL_TOP) ? level_r + LVL_W'(1) : LVL_TOP;
                    sound_r <= 1'b1;
                    state_r <= ST_BUZ;
                end
                ST_BUZ: begin
                    if (done_s) begin
                        sound_r <= 1'b0;
                        if (lives_r == LIV_NONE) begin
                            state_r <= ST_OVER;
                            over_r  <= 1'b1;
                        end else begin
                            state_r <= ST_PLAY;
                        end
                    end else begin
                        state_r <= ST_BUZ;
                    end
                end
                ST_OVER: begin
                    if (restart) begin
                        state_r <= ST_PLAY;
                        over_r  <= 1'b0;
                        level_r <= LVL_MIN;
                        lives_r <= LIV_FULL;
                    end else begin
                        state_r <= ST_OVER;
                    end
                end
                default: begin
                    state_r <= ST_PLAY;
                    sound_r <= 1'b0;
                    over_r  <= 1'b0;
                end
            endcase
        end
    end

    assign select_mux     = sel_s;
    assign take_gate      = (state_r == ST_PLAY) && gate_top_s;
    assign gate_id        = take_gate ? gid_s : {GID_W{1'b0}};
    assign win            = win_r;
    assign lose           = lose_r;
    assign enable_sound   = sound_r;
    assign sound_freq_out = freq_r;
    assign log_enable_out = log_en_s;
    assign level_out      = level_r;
    assign lives_out      = lives_r;
    assign game_over      = over_r;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Self-checking bench for game_flow_ctrl: randomized pixels and game events
// checked against a rule-level model of the game.
module tb_game_flow_ctrl;

    localparam int BUZ = 5;

    logic        clk = 1'b0;
    logic        resetN;
    logic [2:0]  hazard_draw_req;
    logic [1:0]  gate_draw_req;
    logic        frog_draw_req;
    logic        endbank_draw_req;
    logic        restart;
    logic [7:0]  select_mux;
    logic        take_gate;
    logic [0:0]  gate_id;
    logic        win;
    logic        lose;
    logic        enable_sound;
    logic [9:0]  sound_freq_out;
    logic [14:0] log_enable_out;
    logic [2:0]  level_out;
    logic [1:0]  lives_out;
    logic        game_over;

    int checks = 0;
    int errors = 0;
    int m_level;
    int m_lives;
    int m_freq;
    bit m_over;

    always #5 clk = ~clk;

    game_flow_ctrl #(
        .BUZ_CYCLES (BUZ)
    ) dut (
        .clk              (clk),
        .resetN           (resetN),
        .hazard_draw_req  (hazard_draw_req),
        .gate_draw_req    (gate_draw_req),
        .frog_draw_req    (frog_draw_req),
        .endbank_draw_req (endbank_draw_req),
        .restart          (restart),
        .select_mux       (select_mux),
        .take_gate        (take_gate),
        .gate_id          (gate_id),
        .win              (win),
        .lose             (lose),
        .enable_sound     (enable_sound),
        .sound_freq_out   (sound_freq_out),
        .log_enable_out   (log_enable_out),
        .level_out        (level_out),
        .lives_out        (lives_out),
        .game_over        (game_over)
    );

    function automatic logic [14:0] exp_mask(input int lvl);
        int n;
        n = 1 + (lvl - 1) * 5;
        if (n > 15) n = 15;
        return 15'((32'd1 << n) - 32'd1);
    endfunction

    function automatic int exp_sel(input logic [2:0] h, input logic [1:0] g, input logic f, input logic b);
        for (int i = 0; i < 3; i++) if (h[i]) return i + 1;
        for (int j = 0; j < 2; j++) if (g[j]) return 4 + j;
        if (f) return 6;
        if (b) return 7;
        return 0;
    endfunction

    function automatic logic [30:0] exp_status();
        return {3'(m_level), 2'(m_lives), 10'(m_freq), exp_mask(m_level), m_over};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        hazard_draw_req  = 3'd0;
        gate_draw_req    = 2'd0;
        frog_draw_req    = 1'b0;
        endbank_draw_req = 1'b0;
        restart          = 1'b0;
    endtask

    task automatic model_reset();
        m_level = 1;
        m_lives = 3;
        m_freq  = 0;
        m_over  = 1'b0;
    endtask

    // One frog coincidence at cycle t followed by the full burst, with junk collisions during it.
    task automatic do_collision(input bit is_lose, input logic [2:0] h);
        logic [30:0] st;
        frog_draw_req    = 1'b1;
        hazard_draw_req  = is_lose ? h : 3'd0;
        endbank_draw_req = 1'b1;
        gate_draw_req    = 2'($urandom);
        cyc();
        clear_inputs();
        if (is_lose) begin
            m_lives = (m_lives > 0) ? m_lives - 1 : 0;
            m_level = (m_level > 1) ? m_level - 1 : 1;
            m_freq  = 950;
        end else begin
            m_level = (m_level < 4) ? m_level + 1 : 4;
            m_freq  = 500;
        end
        @(negedge clk);
        checks++;
        if ({win, lose, enable_sound} !== {!is_lose, is_lose, 1'b0}) begin
            errors++;
            $display("FAIL event_pulse: win/lose/snd got %b want %b", {win, lose, enable_sound}, {!is_lose, is_lose, 1'b0});
        end
        cyc();
        @(negedge clk);
        st = {level_out, lives_out, sound_freq_out, log_enable_out, game_over};
        checks++;
        if (st !== exp_status() || enable_sound !== 1'b1 || {win, lose} !== 2'b00) begin
            errors++;
            $display("FAIL burst_start: status %h snd %b wl %b want status %h snd 1 wl 00", st, enable_sound, {win, lose}, exp_status());
        end
        for (int k = 1; k < BUZ; k++) begin
            cyc();
            frog_draw_req    = 1'b1;
            hazard_draw_req  = 3'($urandom);
            endbank_draw_req = 1'b1;
            gate_draw_req    = 2'($urandom);
            restart          = 1'($urandom);
            @(negedge clk);
            checks++;
            if ({enable_sound, win, lose, take_gate} !== 4'b1000) begin
                errors++;
                $display("FAIL burst_hold: snd/win/lose/take got %b want 1000 at burst cycle %0d", {enable_sound, win, lose, take_gate}, k);
            end
        end
        cyc();
        clear_inputs();
        m_over = (m_lives == 0);
        @(negedge clk);
        st = {level_out, lives_out, sound_freq_out, log_enable_out, game_over};
        checks++;
        if (st !== exp_status() || {enable_sound, win, lose} !== 3'b000) begin
            errors++;
            $display("FAIL burst_end: status %h snd/win/lose %b want status %h 000", st, {enable_sound, win, lose}, exp_status());
        end
    endtask

    task automatic test_reset();
        logic [30:0] st;
        clear_inputs();
        resetN = 1'b0;
        cyc();
        cyc();
        model_reset();
        @(negedge clk);
        st = {level_out, lives_out, sound_freq_out, log_enable_out, game_over};
        checks++;
        if (st !== exp_status() || log_enable_out !== 15'h0001) begin
            errors++;
            $display("FAIL reset_status: got %h want %h", st, exp_status());
        end
        checks++;
        if ({win, lose, enable_sound, take_gate, gate_id, select_mux} !== 13'd0) begin
            errors++;
            $display("FAIL reset_flags: got %h want 0", {win, lose, enable_sound, take_gate, gate_id, select_mux});
        end
        cyc();
        resetN = 1'b1;
        cyc();
        cyc();
        @(negedge clk);
        st = {level_out, lives_out, sound_freq_out, log_enable_out, game_over};
        checks++;
        if (st !== exp_status() || {win, lose, enable_sound} !== 3'b000) begin
            errors++;
            $display("FAIL idle_status: got %h want %h", st, exp_status());
        end
    endtask

    // Combinational arbitration: drive a pixel for half a cycle only, so no event fires.
    task automatic test_priority();
        logic [2:0]  h;
        logic [1:0]  g;
        logic        f;
        logic        b;
        logic        exp_take;
        logic [0:0]  exp_gid;
        logic [30:0] st;
        for (int n = 0; n < 40; n++) begin
            h = (n == 0) ? 3'b100 : (n == 1) ? 3'b000 : 3'($urandom);
            g = (n < 2) ? 2'b10 : 2'($urandom);
            f = (n < 2) ? 1'b1 : 1'($urandom);
            b = (n < 2) ? 1'b0 : 1'($urandom);
            hazard_draw_req  = h;
            gate_draw_req    = g;
            frog_draw_req    = f;
            endbank_draw_req = b;
            restart          = 1'($urandom);
            exp_take = (h == 3'd0) && (g != 2'd0);
            exp_gid  = (exp_take && !g[0]) ? 1'b1 : 1'b0;
            #4;
            checks++;
            if ({select_mux, take_gate, gate_id} !== {8'(exp_sel(h, g, f, b)), exp_take, exp_gid}) begin
                errors++;
                $display("FAIL priority: h=%b g=%b f=%b b=%b got sel %0d take %b id %b want sel %0d take %b id %b",
                         h, g, f, b, select_mux, take_gate, gate_id, exp_sel(h, g, f, b), exp_take, exp_gid);
            end
            #1;
            clear_inputs();
            cyc();
        end
        @(negedge clk);
        st = {level_out, lives_out, sound_freq_out, log_enable_out, game_over};
        checks++;
        if (st !== exp_status() || {win, lose, enable_sound} !== 3'b000) begin
            errors++;
            $display("FAIL priority_no_event: got %h want %h", st, exp_status());
        end
    endtask

    task automatic test_lose();
        do_collision(1'b1, 3'b010);
    endtask

    task automatic test_win();
        do_collision(1'b0, 3'b000);
        checks++;
        if ({log_enable_out, sound_freq_out, level_out} !== {15'h003F, 10'd500, 3'd2}) begin
            errors++;
            $display("FAIL win_level2: mask %h freq %0d level %0d want 003f 500 2", log_enable_out, sound_freq_out, level_out);
        end
    endtask

    task automatic test_same_cycle();
        do_collision(1'b1, 3'b001);
    endtask

    task automatic restart_game();
        for (int k = 0; k < 4; k++) begin
            frog_draw_req    = 1'b1;
            hazard_draw_req  = 3'($urandom_range(1, 7));
            endbank_draw_req = 1'b1;
            gate_draw_req    = 2'($urandom);
            @(negedge clk);
            checks++;
            if ({game_over, enable_sound, win, lose, take_gate} !== 5'b10000 ||
                select_mux !== 8'(exp_sel(hazard_draw_req, gate_draw_req, 1'b1, 1'b1))) begin
                errors++;
                $display("FAIL over_hold: over/snd/win/lose/take %b sel %0d want 10000 sel %0d",
                         {game_over, enable_sound, win, lose, take_gate}, select_mux,
                         exp_sel(hazard_draw_req, gate_draw_req, 1'b1, 1'b1));
            end
            cyc();
        end
        clear_inputs();
        restart = 1'b1;
        cyc();
        restart = 1'b0;
        model_reset();
        m_freq = 950;
        @(negedge clk);
        checks++;
        if ({level_out, lives_out, sound_freq_out, log_enable_out, game_over} !== exp_status()) begin
            errors++;
            $display("FAIL restart: got %h want %h", {level_out, lives_out, sound_freq_out, log_enable_out, game_over}, exp_status());
        end
    endtask

    task automatic test_over_restart();
        while (!m_over) do_collision(1'b1, 3'b100);
        restart_game();
    endtask

    task automatic test_random_game();
        for (int n = 0; n < 14; n++) begin
            do_collision(1'($urandom), 3'($urandom_range(1, 7)));
            if (m_over) restart_game();
        end
    endtask

    task automatic test_reset_mid_buz();
        logic [30:0] st;
        frog_draw_req    = 1'b1;
        endbank_draw_req = 1'b1;
        cyc();
        clear_inputs();
        cyc();
        cyc();
        resetN = 1'b0;
        cyc();
        model_reset();
        @(negedge clk);
        st = {level_out, lives_out, sound_freq_out, log_enable_out, game_over};
        checks++;
        if (st !== exp_status() || {enable_sound, win, lose} !== 3'b000) begin
            errors++;
            $display("FAIL reset_mid_buz: status %h snd %b want %h 0", st, enable_sound, exp_status());
        end
        resetN = 1'b1;
        cyc();
        do_collision(1'b0, 3'b000);
    endtask

    initial begin
        test_reset();
        test_priority();
        test_lose();
        test_win();
        test_same_cycle();
        test_over_restart();
        test_random_game();
        test_reset_mid_buz();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
